// File: rtl/mesh_term_pkg.sv
// rtl/mesh_term_pkg.sv - packet field layout and RX state type for the mesh terminal port
package mesh_term_pkg;

    // Field positions are offsets below the packet MSB so any packet width can share them.
    localparam int JUMP_MSB = 0;
    localparam int ROW_MSB  = 8;
    localparam int COL_MSB  = 12;
    localparam int MODE_BIT = 16;
    localparam int MAX_W    = 256;

    typedef enum logic {
        RX_IDLE,
        RX_GAP
    } rx_state_t;

    function automatic logic [3:0] get_row(input logic [MAX_W-1:0] pkt, input int sz);
        return 4'(pkt >> (sz - 1 - ROW_MSB - 3));
    endfunction

    function automatic logic [3:0] get_col(input logic [MAX_W-1:0] pkt, input int sz);
        return 4'(pkt >> (sz - 1 - COL_MSB - 3));
    endfunction

endpackage

// File: rtl/mesh_term_port_fifo.sv
// rtl/mesh_term_port_fifo.sv - small register FIFO with head output and simultaneous push/pop
module term_fifo #(
    parameter int width = 40,
    parameter int depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [width-1:0] din,
    input  logic             pop,
    output logic [width-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(depth);

    logic [width-1:0] mem [depth];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_nxt;
    logic             pop_ok;
    logic             push_ok;

    // A pop in the same cycle frees the slot a push into a full buffer needs.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_comb begin
        count_nxt = count;
        if (push_ok && !pop_ok)
            count_nxt = count + 1'b1;
        else if (pop_ok && !push_ok)
            count_nxt = count - 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < depth; i++)
                mem[i] <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count_nxt;
            full  <= (count_nxt == (AW+1)'(depth));
            empty <= (count_nxt == '0);
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/mesh_term_port.sv
// rtl/mesh_term_port.sv - terminal adapter between one device and one mesh_emu edge port
module mesh_term_port
    import mesh_term_pkg::*;
#(
    parameter int pckg_sz    = 40,
    parameter int fifo_depth = 4,
    parameter int ROW_ID     = 0,
    parameter int COL_ID     = 1,
    parameter int CNT_W      = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               tx_push,
    input  logic [pckg_sz-1:0] tx_data,
    output logic               tx_full,
    output logic               mesh_pndng_o,
    output logic [pckg_sz-1:0] mesh_data_o,
    input  logic               mesh_popin,
    input  logic               mesh_pndng_i,
    input  logic [pckg_sz-1:0] mesh_data_i,
    output logic               mesh_pop,
    input  logic               rx_pop,
    output logic [pckg_sz-1:0] rx_data,
    output logic               rx_valid,
    output logic               err_tx_ovf,
    output logic               err_misroute,
    output logic [CNT_W-1:0]   tx_cnt,
    output logic [CNT_W-1:0]   rx_cnt
);
    logic      tx_empty;
    logic      rx_full;
    logic      rx_empty;
    logic      tx_taken;
    logic      tx_drop;
    logic      misrouted;
    rx_state_t rx_state;

    term_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (tx_data),
        .pop   (mesh_popin),
        .dout  (mesh_data_o),
        .full  (tx_full),
        .empty (tx_empty)
    );

    term_fifo #(.width(pckg_sz), .depth(fifo_depth)) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (mesh_pop),
        .din   (mesh_data_i),
        .pop   (rx_pop),
        .dout  (rx_data),
        .full  (rx_full),
        .empty (rx_empty)
    );

    assign mesh_pndng_o = !tx_empty;
    assign rx_valid     = !rx_empty;
    assign tx_taken     = mesh_popin && !tx_empty;
    assign tx_drop      = tx_push && tx_full && !tx_taken;

    // The mesh refreshes pndng/data a cycle after a pop, so RX_GAP skips that stale cycle.
    assign mesh_pop  = (rx_state == RX_IDLE) && mesh_pndng_i && !rx_full;
    assign misrouted = (get_row(MAX_W'(mesh_data_i), pckg_sz) != 4'(ROW_ID)) ||
                       (get_col(MAX_W'(mesh_data_i), pckg_sz) != 4'(COL_ID));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_state     <= RX_IDLE;
            err_tx_ovf   <= 1'b0;
            err_misroute <= 1'b0;
            tx_cnt       <= '0;
            rx_cnt       <= '0;
        end else begin
            case (rx_state)
                RX_IDLE: if (mesh_pop) rx_state <= RX_GAP;
                default: rx_state <= RX_IDLE;
            endcase
            if (tx_drop)
                err_tx_ovf <= 1'b1;
            if (mesh_pop && misrouted)
                err_misroute <= 1'b1;
            if (tx_taken && tx_cnt != '1)
                tx_cnt <= tx_cnt + 1'b1;
            if (mesh_pop && rx_cnt != '1)
                rx_cnt <= rx_cnt + 1'b1;
        end
    end

endmodule
